// File: rtl/div_sequencer_if.sv
// ============================================================================
// Module  : div_sequencer_if
// Purpose : EX-stage <-> divider handshake and operand/result bundle.
// Rev     : 1.0
// ============================================================================
`default_nettype none

interface div_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             signed_div;
  logic             annul;
  logic [WIDTH-1:0] opdata1;
  logic [WIDTH-1:0] opdata2;
  logic [WIDTH-1:0] result_hi;
  logic [WIDTH-1:0] result_lo;
  logic             ready;
  logic             busy;

  modport master (
    output start, signed_div, annul, opdata1, opdata2,
    input  result_hi, result_lo, ready, busy
  );

  modport slave (
    input  start, signed_div, annul, opdata1, opdata2,
    output result_hi, result_lo, ready, busy
  );
endinterface

`default_nettype wire

// File: rtl/div_sequencer.sv
// ============================================================================
// Module  : div_sequencer
// Purpose : Multi-cycle restoring DIV/DIVU, one quotient bit per cycle,
//           remainder -> HI, quotient -> LO, with pipeline stall and annul.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module div_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic            clock,
  input  logic            reset,
  div_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_BYZERO = 2'd1,
    S_ON     = 2'd2,
    S_END    = 2'd3
  } state_e;

  state_e           state_q,    state_d;
  logic [CNT_W-1:0] cnt_q,      cnt_d;
  logic [WIDTH-1:0] rem_q,      rem_d;
  logic [WIDTH-1:0] quot_q,     quot_d;
  logic [WIDTH-1:0] dvsr_q,     dvsr_d;
  logic             neg_quot_q, neg_quot_d;
  logic             neg_rem_q,  neg_rem_d;
  logic [WIDTH-1:0] hi_q,       hi_d;
  logic [WIDTH-1:0] lo_q,       lo_d;
  logic             ready_q,    ready_d;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic             op1_neg;
  logic             op2_neg;

  // One restoring step: bring the next dividend bit into the partial remainder.
  assign shifted = {rem_q, quot_q[WIDTH-1]};
  assign trial   = shifted - {1'b0, dvsr_q};
  assign op1_neg = bus.signed_div & bus.opdata1[WIDTH-1];
  assign op2_neg = bus.signed_div & bus.opdata2[WIDTH-1];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    quot_d     = quot_q;
    dvsr_d     = dvsr_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    ready_d    = ready_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.annul) begin
          rem_d      = '0;
          cnt_d      = '0;
          quot_d     = op1_neg ? -bus.opdata1 : bus.opdata1;
          dvsr_d     = op2_neg ? -bus.opdata2 : bus.opdata2;
          neg_quot_d = op1_neg ^ op2_neg;
          neg_rem_d  = op1_neg;
          state_d    = (bus.opdata2 == '0) ? S_BYZERO : S_ON;
        end
      end

      S_ON: begin
        if (bus.annul) begin
          state_d = S_IDLE;
        end else if (cnt_q == CNT_W'(WIDTH)) begin
          // Magnitudes are done; restore signs (wraps for MIN / -1).
          lo_d    = neg_quot_q ? -quot_q : quot_q;
          hi_d    = neg_rem_q  ? -rem_q  : rem_q;
          ready_d = 1'b1;
          state_d = S_END;
        end else begin
          if (!trial[WIDTH]) begin
            rem_d  = trial[WIDTH-1:0];
            quot_d = {quot_q[WIDTH-2:0], 1'b1};
          end else begin
            rem_d  = shifted[WIDTH-1:0];
            quot_d = {quot_q[WIDTH-2:0], 1'b0};
          end
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_BYZERO: begin
        if (bus.annul) begin
          state_d = S_IDLE;
        end else begin
          hi_d    = '0;
          lo_d    = '0;
          ready_d = 1'b1;
          state_d = S_END;
        end
      end

      S_END: begin
        if (!bus.start || bus.annul) begin
          ready_d = 1'b0;
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      rem_q      <= '0;
      quot_q     <= '0;
      dvsr_q     <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      quot_q     <= quot_d;
      dvsr_q     <= dvsr_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      ready_q    <= ready_d;
    end
  end

  // END drops the stall so the pipeline advances in the cycle ready is seen.
  assign bus.busy      = (state_q == S_ON) || (state_q == S_BYZERO) ||
                         ((state_q == S_IDLE) && bus.start && !bus.annul);
  assign bus.ready     = ready_q;
  assign bus.result_hi = hi_q;
  assign bus.result_lo = lo_q;

endmodule

`default_nettype wire

// File: tb/tb_div_sequencer.sv
// ============================================================================
// Module  : tb_div_sequencer
// Purpose : Directed scoreboard bench for div_sequencer.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module tb_div_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    string       name;
    logic [31:0] lo;
    logic [31:0] hi;
    int          due;
  } exp_t;

  exp_t sb[$];

  div_sequencer_if #(.WIDTH(32)) bus ();

  div_sequencer #(.WIDTH(32), .CNT_W(6)) dut (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: scores each rising ready against the oldest expectation.
  logic        rdy_prev = 1'b0;
  logic [31:0] held_hi, held_lo;
  always @(negedge clk) begin
    exp_t e;
    if (bus.ready && !rdy_prev) begin
      if (sb.size() == 0) begin
        chk("unexpected_ready", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk({e.name, "_lo"}, bus.result_lo, e.lo);
        chk({e.name, "_hi"}, bus.result_hi, e.hi);
        chk({e.name, "_latency"}, 32'(cyc), 32'(e.due));
        chk({e.name, "_busy_at_ready"}, {31'd0, bus.busy}, 32'd0);
      end
      held_hi = bus.result_hi;
      held_lo = bus.result_lo;
    end else if (bus.ready && rdy_prev) begin
      chk("result_hold_hi", bus.result_hi, held_hi);
      chk("result_hold_lo", bus.result_lo, held_lo);
    end
    rdy_prev = bus.ready;
  end

  task automatic push_exp(input string nm, input logic [31:0] lo, input logic [31:0] hi,
                          input int lat);
    exp_t e;
    e.name = nm; e.lo = lo; e.hi = hi; e.due = cyc + lat;
    sb.push_back(e);
  endtask

  // Called at the negedge after the accepting edge; stalls until ready.
  task automatic wait_ready(input string nm);
    bit seen = 0;
    bus.opdata1 = $urandom;
    bus.opdata2 = $urandom;
    for (int i = 0; i < 40; i++) begin
      if (bus.ready) begin seen = 1; break; end
      chk({nm, "_busy"}, {31'd0, bus.busy}, 32'd1);
      @(negedge clk);
    end
    if (!seen) chk({nm, "_timeout"}, 32'd0, 32'd1);
    bus.start = 1'b0;
    @(negedge clk);
    chk({nm, "_ready_drop"}, {31'd0, bus.ready}, 32'd0);
  endtask

  task automatic run_div(input string nm, input logic s, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] lo,
                         input logic [31:0] hi, input int lat);
    bus.start = 1'b1; bus.signed_div = s; bus.opdata1 = a; bus.opdata2 = b;
    push_exp(nm, lo, hi, lat);
    @(negedge clk);
    wait_ready(nm);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit quiet;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.signed_div = 1'b0; bus.annul = 1'b0;
    bus.opdata1 = '0; bus.opdata2 = '0;
    repeat (3) @(negedge clk);
    chk("reset_ready", {31'd0, bus.ready}, 32'd0);
    chk("reset_hi", bus.result_hi, 32'd0);
    chk("reset_lo", bus.result_lo, 32'd0);
    chk("reset_busy", {31'd0, bus.busy}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_div("divu_100_7",  1'b0, 32'd100,       32'd7,         32'd14,         32'd2,          34);
    run_div("div_m7_2",    1'b1, 32'hFFFFFFF9,  32'd2,         32'hFFFFFFFD,   32'hFFFFFFFF,   34);
    run_div("div_7_m2",    1'b1, 32'd7,         32'hFFFFFFFE,  32'hFFFFFFFD,   32'd1,          34);
    run_div("div_m100_m7", 1'b1, 32'hFFFFFF9C,  32'hFFFFFFF9,  32'd14,         32'hFFFFFFFE,   34);
    run_div("divu_byzero", 1'b0, 32'hFFFFFFFF,  32'd0,         32'd0,          32'd0,          2);
    run_div("div_byzero",  1'b1, 32'h80000000,  32'd0,         32'd0,          32'd0,          2);
    run_div("div_ovf",     1'b1, 32'h80000000,  32'hFFFFFFFF,  32'h80000000,   32'd0,          34);
    run_div("divu_max_1",  1'b0, 32'hFFFFFFFF,  32'd1,         32'hFFFFFFFF,   32'd0,          34);
    run_div("divu_0_5",    1'b0, 32'd0,         32'd5,         32'd0,          32'd0,          34);

    // Annul in the middle of a divide (active during E10).
    bus.start = 1'b1; bus.signed_div = 1'b0; bus.opdata1 = 32'd1000; bus.opdata2 = 32'd3;
    repeat (10) @(negedge clk);
    bus.annul = 1'b1;
    @(negedge clk);
    chk("annul_ready", {31'd0, bus.ready}, 32'd0);
    bus.start = 1'b0; bus.annul = 1'b0;
    #1;
    chk("annul_busy", {31'd0, bus.busy}, 32'd0);
    quiet = 1;
    repeat (40) begin @(negedge clk); if (bus.ready) quiet = 0; end
    chk("annul_never_ready", {31'd0, quiet}, 32'd1);
    run_div("divu_9_3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 34);

    // Annul while in BYZERO.
    bus.start = 1'b1; bus.opdata1 = 32'd5; bus.opdata2 = 32'd0;
    @(negedge clk);
    bus.annul = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.annul = 1'b0;
    repeat (2) @(negedge clk);
    chk("annul_byzero_ready", {31'd0, bus.ready}, 32'd0);
    chk("annul_byzero_lo", bus.result_lo, 32'd3);

    // Reset mid-divide (active during E20), then restart with start still high.
    bus.start = 1'b1; bus.signed_div = 1'b0; bus.opdata1 = 32'd1000; bus.opdata2 = 32'd10;
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midreset_ready", {31'd0, bus.ready}, 32'd0);
    chk("midreset_hi", bus.result_hi, 32'd0);
    chk("midreset_lo", bus.result_lo, 32'd0);
    chk("midreset_busy_idle_start", {31'd0, bus.busy}, 32'd1);
    rst_n = 1'b1;
    push_exp("divu_1000_10", 32'd100, 32'd0, 34);
    @(negedge clk);
    wait_ready("divu_1000_10");

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
